// File: rtl/axi4_lite_read_arbiter.sv
// Two-requester (IF / LS) arbiter in front of one AXI4-lite read module.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin, else LS-priority).
module axi4_lite_read_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] IF_R_Addr,
    input  logic              IF_R_Request,
    output logic              IF_R_Finish,
    output logic [DATA_W-1:0] IF_Data_Out,
    input  logic [ADDR_W-1:0] LS_R_Addr,
    input  logic              LS_R_Request,
    output logic              LS_R_Finish,
    output logic [DATA_W-1:0] LS_Data_Out,
    output logic [ADDR_W-1:0] M_R_Addr,
    output logic              M_R_Request,
    input  logic              M_R_Finish,
    input  logic [DATA_W-1:0] M_Data_In,
    output logic [1:0]        Grant,
    output logic              Busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        grant_q;
    logic              req_q;
    logic              busy_q;
    logic              if_fin_q;
    logic              ls_fin_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] ls_data_q;
    logic              pick_ls_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 means LS is favoured on the next simultaneous request
    logic              ptr_q;
`endif

    // Winner selection for an IDLE-cycle grant
    always_comb begin
        pick_ls_d = 1'b0;
        if (LS_R_Request && !IF_R_Request) begin
            pick_ls_d = 1'b1;
        end else if (LS_R_Request && IF_R_Request) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_ls_d = ptr_q;
`else
            pick_ls_d = 1'b1;
`endif
        end
    end

    // Arbitration FSM; every output is a register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            grant_q   <= 2'b00;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            if_fin_q  <= 1'b0;
            ls_fin_q  <= 1'b0;
            if_data_q <= '0;
            ls_data_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q     <= 1'b0;
`endif
        end else begin
            if_fin_q <= 1'b0;
            ls_fin_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (IF_R_Request || LS_R_Request) begin
                        state_q <= S_BUSY;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        grant_q <= pick_ls_d ? 2'b10 : 2'b01;
                        addr_q  <= pick_ls_d ? LS_R_Addr : IF_R_Addr;
                    end
                end
                S_BUSY: begin
                    if (M_R_Finish) begin
                        state_q <= S_RESP;
                        req_q   <= 1'b0;
                        if (grant_q[1]) begin
                            ls_data_q <= M_Data_In;
                            ls_fin_q  <= 1'b1;
                        end else begin
                            if_data_q <= M_Data_In;
                            if_fin_q  <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    grant_q <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
                    // favour whichever side was not just served
                    ptr_q   <= grant_q[0];
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign M_R_Addr    = addr_q;
    assign M_R_Request = req_q;
    assign Grant       = grant_q;
    assign Busy        = busy_q;
    assign IF_R_Finish = if_fin_q;
    assign LS_R_Finish = ls_fin_q;
    assign IF_Data_Out = if_data_q;
    assign LS_Data_Out = ls_data_q;

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Bench for axi4_lite_read_arbiter: directed cases plus randomized
// requesters/downstream checked every cycle against a transaction model.
module tb_axi4_lite_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] IF_R_Addr, LS_R_Addr, M_R_Addr;
    logic        IF_R_Request, LS_R_Request, M_R_Request;
    logic        IF_R_Finish, LS_R_Finish, M_R_Finish;
    logic [63:0] IF_Data_Out, LS_Data_Out, M_Data_In;
    logic [1:0]  Grant;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4_lite_read_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .CLK(clk), .RST(rst),
        .IF_R_Addr(IF_R_Addr), .IF_R_Request(IF_R_Request),
        .IF_R_Finish(IF_R_Finish), .IF_Data_Out(IF_Data_Out),
        .LS_R_Addr(LS_R_Addr), .LS_R_Request(LS_R_Request),
        .LS_R_Finish(LS_R_Finish), .LS_Data_Out(LS_Data_Out),
        .M_R_Addr(M_R_Addr), .M_R_Request(M_R_Request),
        .M_R_Finish(M_R_Finish), .M_Data_In(M_Data_In),
        .Grant(Grant), .Busy(Busy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding read: who owns it, its address, whether the
    // downstream has answered. Side 0 = IF, side 1 = LS.
    bit          t_act, t_ans, t_side, t_last;
    logic [63:0] t_addr, t_dif, t_dls;

    function automatic bit choose(input bit ir, input bit lr, input bit last);
        if (ir && !lr) return 1'b0;
        if (lr && !ir) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return !last;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_act  <= 1'b0;
            t_ans  <= 1'b0;
            t_side <= 1'b0;
            t_last <= 1'b1;
            t_addr <= '0;
            t_dif  <= '0;
            t_dls  <= '0;
        end else if (t_act && t_ans) begin
            t_act  <= 1'b0;
            t_last <= t_side;
        end else if (t_act) begin
            if (M_R_Finish) begin
                t_ans <= 1'b1;
                if (t_side) t_dls <= M_Data_In;
                else        t_dif <= M_Data_In;
            end
        end else if (IF_R_Request || LS_R_Request) begin
            t_act  <= 1'b1;
            t_ans  <= 1'b0;
            t_side <= choose(IF_R_Request, LS_R_Request, t_last);
            t_addr <= choose(IF_R_Request, LS_R_Request, t_last)
                      ? LS_R_Addr : IF_R_Addr;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("grant", 64'(Grant),
            64'(t_act ? (t_side ? 2'b10 : 2'b01) : 2'b00));
        chk("busy", 64'(Busy), 64'(t_act));
        chk("m_req", 64'(M_R_Request), 64'(t_act && !t_ans));
        chk("m_addr", M_R_Addr, t_addr);
        chk("if_fin", 64'(IF_R_Finish), 64'(t_act && t_ans && !t_side));
        chk("ls_fin", 64'(LS_R_Finish), 64'(t_act && t_ans && t_side));
        chk("if_data", IF_Data_Out, t_dif);
        chk("ls_data", LS_Data_Out, t_dls);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starting just after BUSY is entered: answer after lat cycles,
    // return inside the RESP cycle.
    task automatic serve(input int lat, input logic [63:0] d);
        repeat (lat) step();
        M_R_Finish = 1'b1;
        M_Data_In  = d;
        step();
        M_R_Finish = 1'b0;
    endtask

    bit armed;
    int cnt;
    int gap_if, gap_ls;

    initial begin
        rst = 1'b1;
        IF_R_Addr = '0; IF_R_Request = 1'b0;
        LS_R_Addr = '0; LS_R_Request = 1'b0;
        M_R_Finish = 1'b0; M_Data_In = '0;
        step();
        step();
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_grant", 64'(Grant), 64'd0);
        chk("rst_mreq", 64'(M_R_Request), 64'd0);
        rst = 1'b0;

        // reset in the middle of a downstream read
        IF_R_Addr = 64'h8000_0000;
        IF_R_Request = 1'b1;
        step();
        chk("mb_req", 64'(M_R_Request), 64'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mb_busy", 64'(Busy), 64'd0);
        chk("mb_grant", 64'(Grant), 64'd0);
        chk("mb_mreq", 64'(M_R_Request), 64'd0);
        chk("mb_maddr", M_R_Addr, 64'd0);
        IF_R_Request = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mb_nofin", 64'(IF_R_Finish), 64'd0);
        end

        // single IF read, 3-cycle downstream latency
        IF_R_Addr = 64'h8000_0000;
        IF_R_Request = 1'b1;
        step();
        chk("s_maddr", M_R_Addr, 64'h8000_0000);
        chk("s_grant", 64'(Grant), 64'd1);
        serve(2, 64'h0000_0013_0000_0513);
        chk("s_fin", 64'(IF_R_Finish), 64'd1);
        chk("s_data", IF_Data_Out, 64'h0000_0013_0000_0513);
        chk("s_lsfin", 64'(LS_R_Finish), 64'd0);
        IF_R_Request = 1'b0;
        step();
        chk("s_fin1", 64'(IF_R_Finish), 64'd0);

        // simultaneous requests from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        IF_R_Addr = 64'h8000_0000;
        LS_R_Addr = 64'h8000_1000;
        IF_R_Request = 1'b1;
        LS_R_Request = 1'b1;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        chk("sim_first", M_R_Addr, 64'h8000_0000);
        serve(1, 64'hA1);
        IF_R_Request = 1'b0;
`else
        chk("sim_first", M_R_Addr, 64'h8000_1000);
        serve(1, 64'hA1);
        LS_R_Request = 1'b0;
`endif
        step();
        chk("sim_gap", 64'(M_R_Request), 64'd0);
        step();
        chk("sim_req2", 64'(M_R_Request), 64'd1);
`ifdef ARB_ROUND_ROBIN_EN
        chk("sim_second", M_R_Addr, 64'h8000_1000);
        serve(0, 64'hB2);
        LS_R_Request = 1'b0;
`else
        chk("sim_second", M_R_Addr, 64'h8000_0000);
        serve(0, 64'hB2);
        IF_R_Request = 1'b0;
`endif
        step();

        // address changes while waiting and while owning
        LS_R_Addr = 64'h300;
        LS_R_Request = 1'b1;
        step();
        IF_R_Addr = 64'h100;
        IF_R_Request = 1'b1;
        step();
        IF_R_Addr = 64'h200;
        LS_R_Addr = 64'h400;
        step();
        chk("ac_owner", M_R_Addr, 64'h300);
        serve(1, 64'h1234);
        LS_R_Request = 1'b0;
        step();
        step();
        chk("ac_latch", M_R_Addr, 64'h200);
        serve(0, 64'h5555);
        chk("ac_data", IF_Data_Out, 64'h5555);
        IF_R_Request = 1'b0;
        step();

        // stray downstream finish while idle
        M_R_Finish = 1'b1;
        M_Data_In = 64'hDEAD;
        step();
        M_R_Finish = 1'b0;
        chk("st_busy", 64'(Busy), 64'd0);
        chk("st_iffin", 64'(IF_R_Finish), 64'd0);
        chk("st_lsfin", 64'(LS_R_Finish), 64'd0);
        chk("st_ifdat", IF_Data_Out, 64'h5555);
        chk("st_lsdat", LS_Data_Out, 64'h1234);

        // randomized traffic
        armed = 1'b0;
        cnt = 0;
        gap_if = 0;
        gap_ls = 0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (c == 2000) begin
                rst = 1'b1;
                IF_R_Request = 1'b0;
                LS_R_Request = 1'b0;
                M_R_Finish = 1'b0;
                armed = 1'b0;
                step();
                rst = 1'b0;
                continue;
            end
            if (M_R_Request) begin
                if (!armed) begin
                    armed = 1'b1;
                    cnt = $urandom_range(0, 4);
                end
                if (cnt == 0) begin
                    M_R_Finish = 1'b1;
                    M_Data_In = {$urandom, $urandom};
                    armed = 1'b0;
                end else begin
                    cnt--;
                    M_R_Finish = 1'b0;
                end
            end else begin
                armed = 1'b0;
                M_R_Finish = ($urandom_range(0, 9) == 0);
                M_Data_In = {$urandom, $urandom};
            end
            if (IF_R_Request && IF_R_Finish) begin
                IF_R_Request = 1'b0;
                gap_if = $urandom_range(0, 3);
            end else if (!IF_R_Request) begin
                if (gap_if > 0) gap_if--;
                else if ($urandom_range(0, 1) == 1) begin
                    IF_R_Request = 1'b1;
                    IF_R_Addr = {$urandom, $urandom};
                end
            end else if ($urandom_range(0, 7) == 0) begin
                IF_R_Addr = {$urandom, $urandom};
            end
            if (LS_R_Request && LS_R_Finish) begin
                LS_R_Request = 1'b0;
                gap_ls = $urandom_range(0, 3);
            end else if (!LS_R_Request) begin
                if (gap_ls > 0) gap_ls--;
                else if ($urandom_range(0, 1) == 1) begin
                    LS_R_Request = 1'b1;
                    LS_R_Addr = {$urandom, $urandom};
                end
            end else if ($urandom_range(0, 7) == 0) begin
                LS_R_Addr = {$urandom, $urandom};
            end
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_read_arbiter.md
# axi4_lite_read_arbiter

Two-requester arbiter for the shared AXI4-lite read path. The instruction-fetch unit (IF) and the load/store unit (LS) each present a request/address/finish/data interface, and only one is forwarded to the single downstream AXI4-lite read module at a time. The block latches the winning address, holds the downstream request until completion, and returns a registered data word plus a one-cycle finish pulse to the granted requester. It sits between the core front-end/LSU and the AXI4-lite read master/slave pair.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- IF_R_Addr  in  ADDR_W  IF read address; sampled only at grant
- IF_R_Request  in  1  IF level request; held until IF_R_Finish seen
- IF_R_Finish  out  1  one-cycle pulse: IF read complete
- IF_Data_Out  out  DATA_W  IF read data; valid while IF_R_Finish=1
- LS_R_Addr / LS_R_Request / LS_R_Finish / LS_Data_Out  same as IF, for LS
- M_R_Addr  out  ADDR_W  address to downstream read module
- M_R_Request  out  1  downstream request, level
- M_R_Finish  in  1  downstream completion pulse
- M_Data_In  in  DATA_W  downstream data; valid with M_R_Finish
- Grant  out  2  one-hot current owner: [0]=IF, [1]=LS; 0 when idle
- Busy  out  1  1 in any state other than IDLE

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if either request is high, choose a winner, latch its address into M_R_Addr, set Grant, and go to BUSY. Otherwise stay.
- BUSY: M_R_Request=1 and M_R_Addr is stable. When M_R_Finish=1, capture M_Data_In into the data register and go to RESP.
- RESP: M_R_Request=0. The granted side sees Finish=1 and Data_Out equal to the captured data. The other side's Finish stays 0 and its Data_Out holds its last value. Update the priority pointer, clear Grant, and go to IDLE.
- A requester drops its request in the cycle after it sees Finish. A request still high in IDLE is treated as a new read.
- Changes to a requester's address or request while another side owns the path are ignored; the request waits.
- Deassertion of the owner's request during BUSY is ignored. The transaction completes and Finish is still pulsed.
- M_R_Finish outside BUSY is ignored.
- Reset (any time, including mid-BUSY):
  - state=IDLE, Grant=0, Busy=0, M_R_Request=0, M_R_Addr=0
  - both Finish=0, both Data_Out=0, priority pointer=IF
  - An in-flight downstream read is abandoned. The downstream module is reset by the same RST.

## Timing
- Request high in IDLE at edge N: BUSY, M_R_Request=1, Grant valid from cycle N+1.
- M_R_Finish sampled at edge K: RESP in cycle K+1 with the requester Finish pulse. Back in IDLE at K+2.
- Minimum arbiter overhead is 2 cycles: 1 grant + 1 response. Back-to-back grants to alternating requesters occur every (downstream latency + 2) cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin.
  - On simultaneous requests in IDLE, the side not served last wins.
  - The pointer flips to the other side after each RESP.
  - Reset pointer favours IF.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, LS always wins simultaneous requests. The pointer logic is removed.

## Test plan
- Reset mid-BUSY: IF requests 0x8000_0000; assert RST two cycles later -> Busy=0, Grant=0, M_R_Request=0, M_R_Addr=0 asynchronously. After release, no spurious IF_R_Finish.
- Single IF read: IF_R_Addr=0x8000_0000; downstream returns 0x0000_0013_0000_0513 after 3 cycles -> M_R_Addr=0x8000_0000 one cycle after request. IF_R_Finish pulses for exactly 1 cycle with IF_Data_Out=0x0000_0013_0000_0513. LS_R_Finish stays 0.
- Simultaneous requests (IF 0x8000_0000, LS 0x8000_1000) with the macro defined, from reset -> IF served first, then LS. Two M_R_Request episodes with the correct addresses, separated by exactly one M_R_Request=0 cycle after the IDLE return.
- Simultaneous requests with the macro undefined -> LS (0x8000_1000) served first, then IF. With LS re-requesting continuously, IF waits.
- Address change while waiting: LS owns the path; IF_R_Addr changes 0x100 -> 0x200 before grant -> IF grant latches 0x200. The owner's address change during BUSY does not alter M_R_Addr.
- Stray M_R_Finish in IDLE with M_Data_In=0xDEAD -> no Finish pulse, Data_Out unchanged, state stays IDLE.
